i2c_target: RTL and testbench

I2C target (slave) peripheral for the tinyriscv SoC, and the far end of the on-chip `i2c` controller. It answers a 7-bit device address on an external SCL/SDA pair and exposes an 8-byte mailbox register file. The mailbox is read and written by an external I2C controller, and by the core through a RIB slave port (`we_i`/`addr_i`/`data_i`/`data_o`). It raises `int_o` when an external transaction completes.

---
 rtl/i2c_target.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target                                                               |
// | I2C target answering a 7-bit address, exposing an 8-byte mailbox to both |
// | the I2C bus and a RIB slave port, with completion interrupt.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    output logic        int_o
);
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WR_PTR    = 4'd3,
        ST_WR_DATA   = 4'd4,
        ST_WR_ACK    = 4'd5,
        ST_RD_DATA   = 4'd6,
        ST_RD_ACK    = 4'd7,
        ST_WAIT_STOP = 4'd8
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_mb [8];
    logic [2:0] r_ptr;
    logic       r_en, r_ie;
    logic       r_busy, r_wr_done, r_rd_done, r_addr_nack;
    logic       r_wrote, r_read, r_ack_nack, r_sda_oe;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_full, w_addr_hit;
    logic w_shift_in, w_shift_out, w_cnt_clr, w_load_rd, w_mb_wr, w_ptr_load, w_ptr_inc;
    logic w_set_wr_done, w_set_rd_done, w_set_nack, w_set_busy, w_clr_busy;
    logic w_set_wrote, w_set_read, w_clr_txn, w_ack_cap, w_sda_oe_nxt;
    logic [2:0] w_w1c;
    logic w_unused;

    assign w_unused = ^{addr_i[31:4], addr_i[1:0]};

    // Idle bus is high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
    assign w_start     = r_scl_s2 & ~r_sda_s2 & r_sda_d;
    assign w_stop      = r_scl_s2 & r_sda_s2 & ~r_sda_d;
    assign w_byte_full = (r_cnt == 4'd8);
    assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sda_oe <= w_sda_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_in    = 1'b0;
        w_shift_out   = 1'b0;
        w_cnt_clr     = 1'b0;
        w_load_rd     = 1'b0;
        w_mb_wr       = 1'b0;
        w_ptr_load    = 1'b0;
        w_ptr_inc     = 1'b0;
        w_set_wr_done = 1'b0;
        w_set_rd_done = 1'b0;
        w_set_nack    = 1'b0;
        w_set_busy    = 1'b0;
        w_clr_busy    = 1'b0;
        w_set_wrote   = 1'b0;
        w_set_read    = 1'b0;
        w_clr_txn     = 1'b0;
        w_ack_cap     = 1'b0;
        w_sda_oe_nxt  = (r_state == ST_ADDR_ACK) || (r_state == ST_WR_ACK) ||
                        ((r_state == ST_RD_DATA) && !r_shift[7]);
        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_clr_busy    = 1'b1;
            w_clr_txn     = 1'b1;
            w_set_wr_done = r_wrote;
            w_set_rd_done = r_read;
        end else if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_cnt_clr     = 1'b1;
            w_clr_txn     = 1'b1;
            w_set_wr_done = r_wrote;
            w_set_rd_done = r_read;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise && !w_byte_full) begin
                        w_shift_in = 1'b1;
                    end else if (w_scl_fall && w_byte_full) begin
                        if (w_addr_hit && r_en) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_set_busy  = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT_STOP;
                            w_set_nack  = w_addr_hit;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_clr = 1'b1;
                        if (r_shift[0]) begin
                            w_state_nxt = ST_RD_DATA;
                            w_load_rd   = 1'b1;
                        end else begin
                            w_state_nxt = ST_WR_PTR;
                        end
                    end
                end
                ST_WR_PTR, ST_WR_DATA: begin
                    if (w_scl_rise && !w_byte_full) begin
                        w_shift_in = 1'b1;
                    end else if (w_scl_fall && w_byte_full) begin
                        if (r_state == ST_WR_PTR) begin
                            w_ptr_load = 1'b1;
                        end else begin
                            w_mb_wr     = 1'b1;
                            w_ptr_inc   = 1'b1;
                            w_set_wrote = 1'b1;
                        end
                        // EN dropped mid-transfer: finish the byte but leave its ACK slot undriven.
                        w_state_nxt = r_en ? ST_WR_ACK : ST_WAIT_STOP;
                    end
                end
                ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd7) begin
                            w_state_nxt = ST_RD_ACK;
                            w_cnt_clr   = 1'b1;
                            w_set_read  = 1'b1;
                        end else begin
                            w_shift_out = 1'b1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_cap = 1'b1;
                        w_ptr_inc = 1'b1;
                        if (r_sda_s2) begin
                            w_set_rd_done = 1'b1;
                            w_clr_txn     = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        if (!r_ack_nack && r_en) begin
                            w_state_nxt = ST_RD_DATA;
                            w_load_rd   = 1'b1;
                            w_cnt_clr   = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_ack_nack <= 1'b0;
        end else begin
            if (w_cnt_clr)
                r_cnt <= 4'd0;
            else if (w_shift_in || w_shift_out)
                r_cnt <= r_cnt + 4'd1;
            if (w_load_rd)
                r_shift <= r_mb[r_ptr];
            else if (w_shift_in)
                r_shift <= {r_shift[6:0], r_sda_s2};
            else if (w_shift_out)
                r_shift <= {r_shift[6:0], 1'b0};
            if (w_ack_cap)
                r_ack_nack <= r_sda_s2;
        end
    end

    // The I2C byte write is issued last so it overrides a simultaneous RIB write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) r_mb[i] <= 8'h00;
        end else begin
            if (we_i && addr_i[3]) begin
                for (int b = 0; b < 4; b++) r_mb[{addr_i[2], 2'(b)}] <= data_i[8*b +: 8];
            end
            if (w_mb_wr)
                r_mb[r_ptr] <= r_shift;
        end
    end

    assign w_w1c = (we_i && addr_i[3:2] == 2'd1) ? data_i[3:1] : 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en        <= 1'b0;
            r_ie        <= 1'b0;
            r_ptr       <= 3'd0;
            r_busy      <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_addr_nack <= 1'b0;
            r_wrote     <= 1'b0;
            r_read      <= 1'b0;
        end else begin
            if (we_i && addr_i[3:2] == 2'd0) begin
                r_en <= data_i[0];
                r_ie <= data_i[1];
            end
            if (w_ptr_load)
                r_ptr <= r_shift[2:0];
            else if (w_ptr_inc)
                r_ptr <= r_ptr + 3'd1;
            if (w_set_busy)
                r_busy <= 1'b1;
            else if (w_clr_busy)
                r_busy <= 1'b0;
            r_wr_done   <= (r_wr_done & ~w_w1c[0]) | w_set_wr_done;
            r_rd_done   <= (r_rd_done & ~w_w1c[1]) | w_set_rd_done;
            r_addr_nack <= (r_addr_nack & ~w_w1c[2]) | w_set_nack;
            if (w_clr_txn) begin
                r_wrote <= 1'b0;
                r_read  <= 1'b0;
            end else begin
                r_wrote <= r_wrote | w_set_wrote;
                r_read  <= r_read | w_set_read;
            end
        end
    end

    always_comb begin
        data_o = 32'h0;
        case (addr_i[3:2])
            2'd0: data_o = {30'd0, r_ie, r_en};
            2'd1: data_o = {25'd0, r_ptr, r_addr_nack, r_rd_done, r_wr_done, r_busy};
            2'd2: data_o = {r_mb[3], r_mb[2], r_mb[1], r_mb[0]};
            2'd3: data_o = {r_mb[7], r_mb[6], r_mb[5], r_mb[4]};
            default: data_o = 32'h0;
        endcase
    end

    assign sda_oe_o = r_sda_oe;
    assign int_o    = r_ie & (r_wr_done | r_rd_done);

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_target                                                            |
// | Directed plus randomized bench with a byte-level mailbox reference model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_target;
    localparam int HALF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        sda_oe_o;
    logic        int_o;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [7:0] mdl_mb [8];
    logic [2:0] mdl_ptr;

    assign sda_bus = m_sda & ~sda_oe_o;

    i2c_target #(.DEV_ADDR(7'h50)) dut (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .scl_i   (m_scl),
        .sda_i   (sda_bus),
        .sda_oe_o(sda_oe_o),
        .int_o   (int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rib_wr(input logic [1:0] w, input logic [31:0] d);
        addr_i = {28'd0, w, 2'b00};
        data_i = d;
        we_i   = 1'b1;
        wait_clk(1);
        we_i   = 1'b0;
    endtask

    task automatic rib_rd(input logic [1:0] w, output logic [31:0] d);
        addr_i = {28'd0, w, 2'b00};
        #1;
        d = data_o;
    endtask

    function automatic logic [31:0] mdl_word(input int mw);
        return {mdl_mb[4*mw+3], mdl_mb[4*mw+2], mdl_mb[4*mw+1], mdl_mb[4*mw]};
    endfunction

    task automatic mdl_rib(input int mw, input logic [31:0] d);
        for (int b = 0; b < 4; b++) mdl_mb[4*mw+b] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] stat(input logic busy, input logic wr, input logic rd,
                                         input logic nk, input logic [2:0] p);
        return {25'd0, p, nk, rd, wr, busy};
    endfunction

    task automatic bit_out(input logic b);
        wait_clk(HALF/2); m_sda = b; wait_clk(HALF/2); m_scl = 1'b1; wait_clk(HALF); m_scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1; wait_clk(HALF); m_scl = 1'b1; wait_clk(HALF/2); b = sda_bus;
        wait_clk(HALF/2); m_scl = 1'b0;
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wait_clk(HALF/2); m_scl = 1'b1; wait_clk(HALF/2);
        m_sda = 1'b0; wait_clk(HALF/2); m_scl = 1'b0;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wait_clk(HALF/2); m_scl = 1'b1; wait_clk(HALF/2);
        m_sda = 1'b1; wait_clk(HALF);
    endtask

    // With conflict set, a RIB write of all-ones to word 2 lands on the same
    // clock as the target's internal data-byte write.
    task automatic wr_byte(input logic [7:0] d, input logic conflict, output logic ack);
        logic bi;
        for (int i = 7; i >= 0; i--) begin
            bit_out(d[i]);
            if (conflict && i == 0) begin
                wait_clk(2);
                addr_i = 32'h8; data_i = 32'hFFFF_FFFF; we_i = 1'b1;
                wait_clk(1);
                we_i = 1'b0;
            end
        end
        bit_in(bi);
        ack = ~bi;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic bi;
        for (int i = 7; i >= 0; i--) begin
            bit_in(bi);
            d[i] = bi;
        end
        bit_out(nack);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [7:0]  b, p, got;
        logic [4:0]  acks;
        logic        a;
        logic [23:0] rdat;
        int          n;

        for (int i = 0; i < 8; i++) mdl_mb[i] = 8'h00;
        mdl_ptr = 3'd0;

        // Reset state
        wait_clk(4);
        rib_rd(0, rd); check("rst_ctrl", rd, 32'h0);
        rib_rd(1, rd); check("rst_status", rd, 32'h0);
        rib_rd(2, rd); check("rst_mb_lo", rd, 32'h0);
        rib_rd(3, rd); check("rst_mb_hi", rd, 32'h0);
        check("rst_sda_oe", {31'd0, sda_oe_o}, 32'h0);
        check("rst_int", {31'd0, int_o}, 32'h0);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(4);

        // Address-match write with pointer wrap
        rib_wr(0, 32'h3);
        i2c_start;
        wr_byte(8'hA0, 1'b0, acks[0]);
        rib_rd(1, rd); check("busy_mid_write", rd, stat(1, 0, 0, 0, 3'd0));
        wr_byte(8'h06, 1'b0, acks[1]); mdl_ptr = 3'd6;
        wr_byte(8'hA1, 1'b0, acks[2]); mdl_mb[mdl_ptr] = 8'hA1; mdl_ptr++;
        wr_byte(8'hB2, 1'b0, acks[3]); mdl_mb[mdl_ptr] = 8'hB2; mdl_ptr++;
        wr_byte(8'hC3, 1'b0, acks[4]); mdl_mb[mdl_ptr] = 8'hC3; mdl_ptr++;
        i2c_stop;
        check("write_acks", {27'd0, acks}, 32'h1F);
        rib_rd(2, rd); check("write_mb_lo", rd, mdl_word(0));
        rib_rd(3, rd); check("write_mb_hi", rd, mdl_word(1));
        rib_rd(1, rd); check("write_status", rd, stat(0, 1, 0, 0, mdl_ptr));
        check("write_int", {31'd0, int_o}, 32'h1);

        rib_wr(1, 32'hE);
        rib_rd(1, rd); check("w1c_status", rd, stat(0, 0, 0, 0, mdl_ptr));
        check("w1c_int", {31'd0, int_o}, 32'h0);

        // Read with controller NACK on the last byte
        rib_wr(2, 32'h4433_2211); mdl_rib(0, 32'h4433_2211);
        i2c_start;
        wr_byte(8'hA0, 1'b0, acks[0]);
        wr_byte(8'h01, 1'b0, acks[1]); mdl_ptr = 3'd1;
        i2c_start;
        wr_byte(8'hA1, 1'b0, acks[2]);
        for (int k = 0; k < 3; k++) begin
            rd_byte(k == 2, got);
            rdat[8*k +: 8] = got;
        end
        check("read_acks", {29'd0, acks[2:0]}, 32'h7);
        check("read_data", {8'd0, rdat}, {8'd0, mdl_mb[3], mdl_mb[2], mdl_mb[1]});
        mdl_ptr = mdl_ptr + 3'd3;
        wait_clk(6);
        check("read_sda_released", {31'd0, sda_oe_o}, 32'h0);
        rib_rd(1, rd); check("read_status_nack", rd, stat(1, 0, 1, 0, mdl_ptr));
        check("read_int", {31'd0, int_o}, 32'h1);
        i2c_stop;
        rib_rd(1, rd); check("read_status_stop", rd, stat(0, 0, 1, 0, mdl_ptr));
        rib_wr(1, 32'hE);

        // Address mismatch, then enabled=0
        i2c_start;
        wr_byte(8'hA2, 1'b0, acks[0]);
        wr_byte(8'h00, 1'b0, acks[1]);
        i2c_stop;
        check("mismatch_acks", {30'd0, acks[1:0]}, 32'h0);
        rib_rd(1, rd); check("mismatch_status", rd, stat(0, 0, 0, 0, mdl_ptr));

        rib_wr(0, 32'h2);
        i2c_start;
        wr_byte(8'hA0, 1'b0, a);
        check("disabled_ack", {31'd0, a}, 32'h0);
        rib_rd(1, rd); check("disabled_status", rd, stat(0, 0, 0, 1, mdl_ptr));
        i2c_stop;
        check("disabled_int", {31'd0, int_o}, 32'h0);
        rib_wr(1, 32'hE);
        rib_wr(0, 32'h3);

        // RIB/I2C write to the same mailbox byte in the same cycle
        i2c_start;
        wr_byte(8'hA0, 1'b0, acks[0]);
        wr_byte(8'h01, 1'b0, acks[1]); mdl_ptr = 3'd1;
        wr_byte(8'h5A, 1'b1, acks[2]);
        mdl_rib(0, 32'hFFFF_FFFF); mdl_mb[mdl_ptr] = 8'h5A; mdl_ptr++;
        i2c_stop;
        check("conflict_acks", {29'd0, acks[2:0]}, 32'h7);
        rib_rd(2, rd); check("conflict_word", rd, mdl_word(0));
        rib_rd(1, rd); check("conflict_status", rd, stat(0, 1, 0, 0, mdl_ptr));
        rib_wr(1, 32'hE);

        // STOP after four bits of a data byte
        i2c_start;
        wr_byte(8'hA0, 1'b0, acks[0]);
        wr_byte(8'h03, 1'b0, acks[1]); mdl_ptr = 3'd3;
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        i2c_stop;
        check("abort_acks", {30'd0, acks[1:0]}, 32'h3);
        rib_rd(2, rd); check("abort_mb_lo", rd, mdl_word(0));
        rib_rd(3, rd); check("abort_mb_hi", rd, mdl_word(1));
        rib_rd(1, rd); check("abort_status", rd, stat(0, 0, 0, 0, mdl_ptr));
        check("abort_sda_oe", {31'd0, sda_oe_o}, 32'h0);

        // Randomized writes and reads against the mailbox model
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 1);
            d = $urandom;
            rib_wr(2'(n + 2), d); mdl_rib(n, d);

            n = $urandom_range(1, 4);
            p = 8'($urandom);
            i2c_start;
            wr_byte(8'hA0, 1'b0, a); acks = {4'd0, a};
            wr_byte(p, 1'b0, a); acks[0] = acks[0] & a; mdl_ptr = p[2:0];
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                wr_byte(b, 1'b0, a); acks[0] = acks[0] & a;
                mdl_mb[mdl_ptr] = b; mdl_ptr++;
            end
            i2c_stop;
            check("rand_write_acks", {31'd0, acks[0]}, 32'h1);

            n = $urandom_range(1, 4);
            p = 8'($urandom);
            i2c_start;
            wr_byte(8'hA0, 1'b0, a); acks[0] = a;
            wr_byte(p, 1'b0, a); acks[0] = acks[0] & a; mdl_ptr = p[2:0];
            i2c_start;
            wr_byte(8'hA1, 1'b0, a); acks[0] = acks[0] & a;
            check("rand_read_acks", {31'd0, acks[0]}, 32'h1);
            for (int k = 0; k < n; k++) begin
                rd_byte(k == n - 1, got);
                check("rand_read_byte", {24'd0, got}, {24'd0, mdl_mb[mdl_ptr]});
                mdl_ptr++;
            end
            i2c_stop;
            rib_rd(1, rd); check("rand_status", rd, stat(0, 1, 1, 0, mdl_ptr));
            rib_rd(2, rd); check("rand_mb_lo", rd, mdl_word(0));
            rib_rd(3, rd); check("rand_mb_hi", rd, mdl_word(1));
            check("rand_int", {31'd0, int_o}, 32'h1);
            rib_wr(1, 32'hE);
        end

        // Asynchronous reset while the target drives SDA low
        rib_wr(2, 32'h0102_0304);
        rib_wr(3, 32'h7F7F_7F7F);
        i2c_start;
        wr_byte(8'hA1, 1'b0, a);
        check("rstmid_ack", {31'd0, a}, 32'h1);
        wait_clk(6);
        check("rstmid_driving", {31'd0, sda_oe_o}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_sda_oe", {31'd0, sda_oe_o}, 32'h0);
        check("rstmid_int", {31'd0, int_o}, 32'h0);
        rib_rd(0, rd); check("rstmid_ctrl", rd, 32'h0);
        rib_rd(1, rd); check("rstmid_status", rd, 32'h0);
        rib_rd(2, rd); check("rstmid_mb_lo", rd, 32'h0);
        rib_rd(3, rd); check("rstmid_mb_hi", rd, 32'h0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
